if_id_reg: RTL

//  IF/ID pipeline register between the fetch unit and the decode stage.

---
 rtl/if_id_reg_pkg.sv | 26 ++
 rtl/if_id_reg_sat_counter.sv | 26 ++
 rtl/if_id_reg.sv | 91 +++++++++
 3 files changed

// File: rtl/if_id_reg_pkg.sv
// Shared fetch/decode constants, exception codes and fetch exception classifier for if_id_reg.
package if_id_reg_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] IMEM_BYTES    = 32'd16384;      // also sizes the fetch unit's memory

    typedef enum logic [1:0] {
        EXC_NONE  = 2'b00,
        EXC_ALIGN = 2'b01,
        EXC_RANGE = 2'b10
    } exc_e;

    // Misalignment wins over range; the subtraction wraps so one unsigned compare covers both bounds.
    function automatic exc_e fetch_exc(input logic [31:0] pc4, input logic [31:0] base);
        logic [31:0] pc_f;
        pc_f = pc4 - 32'd4;
        if (pc4[1:0] != 2'b00)
            return EXC_ALIGN;
        else if ((pc_f - base) >= IMEM_BYTES)
            return EXC_RANGE;
        else
            return EXC_NONE;
    endfunction

endpackage

// File: rtl/if_id_reg_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold, flush bubble and stall/flush event counters.
// Define FETCH_EXC_EN to classify fetch exceptions (misaligned / out-of-range PC) onto exc_D.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             stock,
    input  logic             flush,
    input  logic [31:0]      PC4_F,
    input  logic [31:0]      Instr_F,
    output logic [31:0]      PC4_D,
    output logic [31:0]      PC_D,
    output logic [31:0]      Instr_D,
    output logic             valid_D,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       exc_D
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [1:0]  exc_q, exc_d;
    logic [1:0]  exc_load;

`ifdef FETCH_EXC_EN
    assign exc_load = fetch_exc(PC4_F, RESET_PC);
`else
    assign exc_load = EXC_NONE;
`endif

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        exc_d   = exc_q;
        if (flush) begin
            // PC still advances on a bubble so the squashed slot stays traceable
            instr_d = NOP_INSTR;
            pc4_d   = PC4_F;
            valid_d = 1'b0;
            exc_d   = EXC_NONE;
        end else if (!stock) begin
            // a faulting fetch still presents as valid so decode can trap on exc_D
            instr_d = (exc_load != EXC_NONE) ? NOP_INSTR : Instr_F;
            pc4_d   = PC4_F;
            valid_d = 1'b1;
            exc_d   = exc_load;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= RESET_PC + 32'd4;
            valid_q <= 1'b0;
            exc_q   <= EXC_NONE;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            exc_q   <= exc_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .inc_i  (stock),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .inc_i  (flush),
        .cnt_o  (flush_cnt)
    );

    assign Instr_D = instr_q;
    assign PC4_D   = pc4_q;
    assign PC_D    = pc4_q - 32'd4;
    assign valid_D = valid_q;
    assign exc_D   = exc_q;

endmodule
